match_controller: RTL

Game-flow sequencer for the two-player fighting game. Sits between the keyboard/keycode sources, the player and health logic, and the menu/colour-mapping path. Runs the match state machine: menu, per-round countdown, fight, pause, round-over hold, match-over. Gates player motion, pulses per-round player resets, tracks round wins and reports the winner.

---
 rtl/match_controller.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/match_controller.sv
// Game-flow sequencer for the two-player fighting game: menu, countdown, fight,
// pause, round-over hold and match-over, with round tally and winner report.
module match_controller #(
  parameter int COUNTDOWN_SECS   = 3,
  parameter int FRAMES_PER_SEC   = 60,
  parameter int ROUNDOVER_FRAMES = 120,
  parameter int ROUNDS_TO_WIN    = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start,
  input  logic       pause_key,
  input  logic [9:0] p1_health,
  input  logic [9:0] p2_health,
  output logic [2:0] state,
  output logic       is_menu,
  output logic       paused,
  output logic       fight_en,
  output logic       round_reset,
  output logic [1:0] countdown_sec,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [1:0] winner
);

  localparam int CNT_MAX = (FRAMES_PER_SEC > ROUNDOVER_FRAMES) ? FRAMES_PER_SEC : ROUNDOVER_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FPS_L  = CNT_W'(FRAMES_PER_SEC);
  localparam logic [CNT_W-1:0] ROF_L  = CNT_W'(ROUNDOVER_FRAMES);
  localparam logic [1:0]       SECS_L = 2'(COUNTDOWN_SECS);
  localparam logic [1:0]       RTW_L  = 2'(ROUNDS_TO_WIN);

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  typedef enum logic [2:0] {
    S_MENU       = 3'd0,
    S_COUNTDOWN  = 3'd1,
    S_FIGHT      = 3'd2,
    S_PAUSE      = 3'd3,
    S_ROUND_OVER = 3'd4,
    S_MATCH_OVER = 3'd5
  } state_t;

  logic             r_sync1, r_sync2, r_sync2_d, r_tick;
  logic             r_start_d, r_pause_d;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [1:0]       r_sec, w_sec_nxt;
  logic [1:0]       r_p1_rounds, w_p1_nxt, w_p1_sat;
  logic [1:0]       r_p2_rounds, w_p2_nxt, w_p2_sat;
  logic [1:0]       r_winner, w_winner_nxt;
  logic             r_is_menu, r_paused, r_fight_en, r_round_reset;
  logic             w_start_e, w_pause_e, w_p1_ko, w_p2_ko, w_entry_cd, w_entry_ro;

  // frame_clk crosses domains through two flops; the tick is its registered rising edge.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
      r_tick    <= 1'b0;
      r_start_d <= 1'b1;
      r_pause_d <= 1'b1;
    end else begin
      r_sync1   <= frame_clk;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
      r_tick    <= r_sync2 & ~r_sync2_d;
      r_start_d <= start;
      r_pause_d <= pause_key;
    end
  end

  assign w_start_e = start & ~r_start_d;
  assign w_pause_e = pause_key & ~r_pause_d;
  assign w_p1_ko   = (p1_health == 10'd0);
  assign w_p2_ko   = (p2_health == 10'd0);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_p1_sat  = (r_p1_rounds < RTW_L) ? r_p1_rounds + 2'd1 : r_p1_rounds;
  assign w_p2_sat  = (r_p2_rounds < RTW_L) ? r_p2_rounds + 2'd1 : r_p2_rounds;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sec_nxt    = r_sec;
    w_p1_nxt     = r_p1_rounds;
    w_p2_nxt     = r_p2_rounds;
    w_winner_nxt = r_winner;

    case (r_state)
      S_MENU: begin
        if (w_start_e) begin
          w_state_nxt  = S_COUNTDOWN;
          w_p1_nxt     = 2'd0;
          w_p2_nxt     = 2'd0;
          w_winner_nxt = WIN_NONE;
        end
      end
      S_COUNTDOWN: begin
        if (r_tick) begin
          if (w_cnt_inc == FPS_L) begin
            w_cnt_nxt = '0;
            if (r_sec <= 2'd1) w_state_nxt = S_FIGHT;
            else               w_sec_nxt   = r_sec - 2'd1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_FIGHT: begin
        // A knockout outranks a pause request taken in the same cycle.
        if (w_p1_ko && w_p2_ko) begin
          w_state_nxt  = S_ROUND_OVER;
          w_winner_nxt = WIN_DRAW;
        end else if (w_p1_ko) begin
          w_state_nxt  = S_ROUND_OVER;
          w_p2_nxt     = w_p2_sat;
          w_winner_nxt = WIN_P2;
        end else if (w_p2_ko) begin
          w_state_nxt  = S_ROUND_OVER;
          w_p1_nxt     = w_p1_sat;
          w_winner_nxt = WIN_P1;
        end else if (w_pause_e) begin
          w_state_nxt  = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (w_pause_e) w_state_nxt = S_FIGHT;
      end
      S_ROUND_OVER: begin
        if (r_tick) begin
          if (w_cnt_inc == ROF_L) begin
            if (r_p1_rounds == RTW_L) begin
              w_state_nxt  = S_MATCH_OVER;
              w_winner_nxt = WIN_P1;
            end else if (r_p2_rounds == RTW_L) begin
              w_state_nxt  = S_MATCH_OVER;
              w_winner_nxt = WIN_P2;
            end else begin
              w_state_nxt  = S_COUNTDOWN;
              w_winner_nxt = WIN_NONE;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_MATCH_OVER: begin
        if (w_start_e) w_state_nxt = S_MENU;
      end
      default: w_state_nxt = S_MENU;
    endcase

    w_entry_cd = (w_state_nxt == S_COUNTDOWN) && (r_state != S_COUNTDOWN);
    w_entry_ro = (w_state_nxt == S_ROUND_OVER) && (r_state != S_ROUND_OVER);
    if (w_entry_cd) begin
      w_cnt_nxt = '0;
      w_sec_nxt = SECS_L;
    end
    if (w_entry_ro) w_cnt_nxt = '0;
    if (w_state_nxt != S_COUNTDOWN) w_sec_nxt = 2'd0;
  end

  // Flags are decoded from the next state so every output is a flop.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_MENU;
      r_cnt         <= '0;
      r_sec         <= 2'd0;
      r_p1_rounds   <= 2'd0;
      r_p2_rounds   <= 2'd0;
      r_winner      <= WIN_NONE;
      r_is_menu     <= 1'b1;
      r_paused      <= 1'b0;
      r_fight_en    <= 1'b0;
      r_round_reset <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_sec         <= w_sec_nxt;
      r_p1_rounds   <= w_p1_nxt;
      r_p2_rounds   <= w_p2_nxt;
      r_winner      <= w_winner_nxt;
      r_is_menu     <= (w_state_nxt == S_MENU);
      r_paused      <= (w_state_nxt == S_PAUSE);
      r_fight_en    <= (w_state_nxt == S_FIGHT);
      r_round_reset <= w_entry_cd;
    end
  end

  assign state         = r_state;
  assign is_menu       = r_is_menu;
  assign paused        = r_paused;
  assign fight_en      = r_fight_en;
  assign round_reset   = r_round_reset;
  assign countdown_sec = r_sec;
  assign p1_rounds     = r_p1_rounds;
  assign p2_rounds     = r_p2_rounds;
  assign winner        = r_winner;

endmodule
